// File: rtl/tone_pkg.sv
// Shared tone definitions: note codes and the nominal period table used by
// both the tone player and the tone decoder.
package tone_pkg;

    localparam int TONE_CNT_W = 20;

    localparam logic [3:0] NOTE_NONE    = 4'd0;
    localparam logic [3:0] NOTE_ALTO3   = 4'd1;
    localparam logic [3:0] NOTE_ALTO5   = 4'd2;
    localparam logic [3:0] NOTE_ALTO6   = 4'd3;
    localparam logic [3:0] NOTE_ALTO7   = 4'd4;
    localparam logic [3:0] NOTE_TREBLE1 = 4'd5;
    localparam logic [3:0] NOTE_TREBLE2 = 4'd6;
    localparam logic [3:0] NOTE_TREBLE3 = 4'd7;
    localparam logic [3:0] NOTE_TREBLE5 = 4'd8;
    localparam logic [3:0] NOTE_DTREB1  = 4'd9;
    localparam logic [3:0] NOTE_REST    = 4'd10;

    // Period = 40 * (32768 - preset) clk_50M cycles; zero marks an unused code.
    localparam int unsigned NOTE_PERIOD [16] = '{
        0, 303400, 255160, 227320, 202520, 191160, 170280, 151720,
        127600, 95600, 655400, 0, 0, 0, 0, 0
    };

    typedef enum logic [1:0] {
        ST_SILENT,
        ST_ARMED,
        ST_CANDIDATE,
        ST_LOCKED
    } tone_state_t;

endpackage

// File: rtl/tone_period_classifier.sv
// Maps a measured period to the unique note whose inclusive window
// nominal +/- (nominal >> TOL_SHIFT) contains it, or NOTE_NONE.
module tone_period_classifier
    import tone_pkg::*;
#(
    parameter int          CNT_W      = TONE_CNT_W,
    parameter int          TOL_SHIFT  = 6,
    parameter int unsigned PERIOD_DIV = 1
) (
    input  logic [CNT_W-1:0] meas,
    output logic [3:0]       note_class
);

    logic [31:0] meas32;
    int unsigned nom;
    int unsigned tol;

    assign meas32 = 32'(meas);

    always_comb begin
        note_class = NOTE_NONE;
        nom        = 0;
        tol        = 0;
        for (int c = 1; c < 16; c++) begin
            nom = NOTE_PERIOD[c] / PERIOD_DIV;
            tol = nom >> TOL_SHIFT;
            if (nom != 0 && meas32 >= nom - tol && meas32 <= nom + tol)
                note_class = 4'(c);
        end
        // A saturated counter means "too long to measure", never a note.
        if (meas == '1)
            note_class = NOTE_NONE;
    end

endmodule

// File: rtl/tone_decoder.sv
// Tone line receiver: synchronizes tone_in, measures the rising-edge period
// and locks onto a note after LOCK_COUNT consecutive matching periods.
module tone_decoder
    import tone_pkg::*;
#(
    parameter int          CNT_W      = TONE_CNT_W,
    parameter int          LOCK_COUNT = 3,
    parameter int          TOL_SHIFT  = 6,
    parameter int          TIMEOUT    = 720000,
    parameter int unsigned PERIOD_DIV = 1
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic             tone_in,
    output logic [3:0]       note_code,
    output logic             note_valid,
    output logic             note_strobe,
    output logic [CNT_W-1:0] period_out
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [3:0]       LOCK_HITS   = 4'(LOCK_COUNT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic             sync_p0, sync_p1, sync_p2;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] meas_p0;
    logic             vld_p0;
    logic [3:0]       class_comb;
    logic [3:0]       class_p1;
    logic             vld_p1;
    tone_state_t      state, state_n;
    logic [3:0]       cand, cand_n;
    logic [3:0]       hits, hits_n, next_hits;
    logic [3:0]       code_n;
    logic             valid_n, strobe_n;

    // Stage: two-flop synchronizer plus edge-detect flop
    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= tone_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~sync_p2;

    // Stage p0: period counter; the edge that arms from SILENT is not measured
    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            meas_p0 <= '0;
            vld_p0  <= 1'b0;
        end else begin
            vld_p0 <= 1'b0;
            if (rise) begin
                cnt <= '0;
                if (state != ST_SILENT) begin
                    meas_p0 <= sat_inc(cnt);
                    vld_p0  <= 1'b1;
                end
            end else begin
                cnt <= sat_inc(cnt);
            end
        end
    end

    assign period_out = meas_p0;

    tone_period_classifier #(
        .CNT_W      (CNT_W),
        .TOL_SHIFT  (TOL_SHIFT),
        .PERIOD_DIV (PERIOD_DIV)
    ) u_classifier (
        .meas       (meas_p0),
        .note_class (class_comb)
    );

    // Stage p1: registered classification
    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            class_p1 <= NOTE_NONE;
            vld_p1   <= 1'b0;
        end else begin
            class_p1 <= class_comb;
            vld_p1   <= vld_p0;
        end
    end

    // Stage p2: lock FSM and outputs
    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            state       <= ST_SILENT;
            cand        <= NOTE_NONE;
            hits        <= '0;
            note_code   <= NOTE_NONE;
            note_valid  <= 1'b0;
            note_strobe <= 1'b0;
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            hits        <= hits_n;
            note_code   <= code_n;
            note_valid  <= valid_n;
            note_strobe <= strobe_n;
        end
    end

    always_comb begin
        state_n   = state;
        cand_n    = cand;
        hits_n    = hits;
        code_n    = note_code;
        valid_n   = note_valid;
        strobe_n  = 1'b0;
        next_hits = 4'd1;
        if (state == ST_CANDIDATE && class_p1 == cand)
            next_hits = hits + 4'd1;

        case (state)
            ST_SILENT: begin
                if (rise)
                    state_n = ST_ARMED;
            end
            default: begin
                // An edge in the timeout cycle wins over the timeout.
                if (!rise && cnt >= TIMEOUT_CNT) begin
                    state_n = ST_SILENT;
                    code_n  = NOTE_NONE;
                    valid_n = 1'b0;
                    hits_n  = '0;
                end else if (vld_p1) begin
                    if (class_p1 == NOTE_NONE) begin
                        state_n = ST_ARMED;
                        hits_n  = '0;
                    end else if (!(state == ST_LOCKED && class_p1 == note_code)) begin
                        cand_n = class_p1;
                        hits_n = next_hits;
                        if (next_hits >= LOCK_HITS) begin
                            state_n  = ST_LOCKED;
                            code_n   = class_p1;
                            valid_n  = 1'b1;
                            strobe_n = !note_valid || (class_p1 != note_code);
                        end else begin
                            state_n = ST_CANDIDATE;
                        end
                    end
                end
            end
        endcase
    end

endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Receive side of the speaker tone interface: samples an asynchronous square-wave tone line (e.g. another board's speaker output), measures its rising-edge-to-rising-edge period in clk_50M cycles, and decodes it to a note code.
- The nominal period table matches the player's tone synthesis: period = 40 × (32768 − preset), in clk_50M cycles.
- Outputs a debounced note code plus a change strobe, for display/scoring logic downstream.

Parameters:
- CNT_W, 20, width of the period counter and period_out; counter saturates at 2^CNT_W−1.
- LOCK_COUNT, 3, consecutive in-window periods of the same note required to lock (range 1..15).
- TOL_SHIFT, 6, match window = nominal ± (nominal >> TOL_SHIFT), bounds inclusive (≈±1.6%).
- TIMEOUT, 720000, cycles without a rising edge before declaring silence; must exceed the REST period plus its tolerance.

Ports:
- clk_50M, input, 1, system clock, 50 MHz.
- rst, input, 1, asynchronous active-low reset.
- tone_in, input, 1, asynchronous square-wave tone line (any duty cycle).
- note_code, output, 4, decoded note (codes listed under Behaviour).
- note_valid, output, 1, high while a note is locked.
- note_strobe, output, 1, one-cycle pulse when note_valid rises or note_code changes while valid.
- period_out, output, CNT_W, last measured raw period in cycles.

Behaviour:
- Reset (rst=0, async): all registers clear. note_code=0, note_valid=0, note_strobe=0, period_out=0. FSM enters SILENT; synchronizer flops are cleared to 0.
- Note codes and nominal periods (cycles):
  - 0 NONE
  - 1 alto3 = 303400
  - 2 alto5 = 255160
  - 3 alto6 = 227320
  - 4 alto7 = 202520
  - 5 treble1 = 191160
  - 6 treble2 = 170280
  - 7 treble3 = 151720
  - 8 treble5 = 127600
  - 9 dbl-treble1 = 95600
  - 10 REST = 655400
  - 11–15 unused.
  - Windows do not overlap at TOL_SHIFT ≥ 6; the class is the unique matching code, or 0 if none matches.
- Input path: 2-FF synchronizer on tone_in, then a 3rd flop for edge detect. A rising edge is flagged when s2=1 and s3=0.
- Period counter:
  - Increments every cycle and saturates.
  - On an edge: meas ← cnt+1 and cnt ← 0.
  - period_out updates on every measured edge, from ARMED onward.
  - The first edge after SILENT produces no measurement.
- Classification is registered one cycle after the edge. The FSM acts on the following cycle.
- Fixed latency: 4 clk_50M cycles from the first cycle tone_in is sampled high to the output update.
- FSM (hits is a 4-bit register; cand is the candidate code):
  - SILENT: on edge → ARMED.
  - ARMED: on class c≠0 → CANDIDATE, cand=c, hits=1; class 0 → stay ARMED.
  - CANDIDATE:
    - class==cand → hits+1. When hits reaches LOCK_COUNT → LOCKED, note_code←cand, note_valid←1. Pulse note_strobe only if note_valid was 0 or cand≠old note_code.
    - class≠cand and class≠0 → cand=class, hits=1.
    - class 0 → ARMED.
  - LOCKED: class==note_code → stay. Any other class → CANDIDATE (or ARMED if class 0), using the same rules as above.
  - note_valid and note_code hold their old values until a new lock or a timeout.
  - LOCK_COUNT=1 → lock on the first matching period.
- Timeout: cnt reaching TIMEOUT in any state except SILENT → SILENT on the next cycle, with note_valid←0, note_code←0, hits←0, and no strobe.
- Simultaneous events: an edge in the same cycle cnt hits TIMEOUT is treated as the edge (no timeout). A saturated counter value never matches any window.
- Reset mid-lock: outputs clear immediately. Re-locking requires LOCK_COUNT+1 edges after release.

Decomposition:
- tone_pkg holds:
  - note code constants (NOTE_NONE … NOTE_REST);
  - the nominal period table as a constant array indexed by code;
  - the CNT_W default.
- The package is shared with the player so both ends use one table.
- One sub-module: tone_period_classifier. It is combinational: meas and TOL_SHIFT in → class code out, with an inclusive window compare over the table.
- Synchronizer, counter and FSM live in tone_decoder.

Test Plan:
- Reset check: hold rst=0 with tone_in toggling → all outputs 0. Release → no lock before 4 edges.
- Lock on alto5: square wave, period 255160, LOCK_COUNT=3 → note_valid=1, note_code=2, one note_strobe, period_out=255160. Outputs update exactly 4 cycles after the 4th rising edge.
- Window bounds (nominal 255160, tol 3986):
  - period 259146 → locks to code 2 (inclusive bound);
  - period 259147 and period 262815 → never valid; FSM stays ARMED; period_out tracks.
- Note change: locked on 191160 (code 5), switch to 170280 → code 5 and valid held across 2 edges, then code 6 with a single strobe. A single odd-length transition period must not unlock.
- Silence: stop toggling after lock → note_valid=0, note_code=0 when cnt reaches 720000; no strobe. A REST tone at 655400 locks as code 10 and does not time out.
- Async reset mid-lock: assert rst between clocks → outputs 0 immediately. Release with the tone still running → relock after 4 edges.
